// File: rtl/sram_buffer_row_loader_if.sv
// ---------------------------------------------------------------------------
// sram_buffer_row_loader_if
//
// Bundles the control, element-stream and SRAM write-port signals of the
// row loader.
//   start, num_rows               load request (driver -> loader)
//   s_valid, s_data, s_ready      8-bit element stream handshake
//   sram_csb, sram_web            buffer chip select / write enable, active low
//   sram_addr, sram_wdata         buffer row address and packed row data
//   busy, done                    load status (loader -> controller)
// Modports:
//   slave  - the loader itself
//   master - whatever drives the stream and consumes the SRAM pins
// ---------------------------------------------------------------------------
interface sram_buffer_row_loader_if #(
    parameter int ARR_WIDTH = 16,
    parameter int ADDR_W    = 7
) ();

    logic                     start;
    logic [7:0]               num_rows;
    logic                     s_valid;
    logic [7:0]               s_data;
    logic                     s_ready;
    logic                     sram_csb;
    logic                     sram_web;
    logic [ADDR_W-1:0]        sram_addr;
    logic [ARR_WIDTH*8-1:0]   sram_wdata;
    logic                     busy;
    logic                     done;

    modport slave (
        input  start, num_rows, s_valid, s_data,
        output s_ready, sram_csb, sram_web, sram_addr, sram_wdata, busy, done
    );

    modport master (
        output start, num_rows, s_valid, s_data,
        input  s_ready, sram_csb, sram_web, sram_addr, sram_wdata, busy, done
    );

endinterface

// File: rtl/sram_buffer_row_loader.sv
// ---------------------------------------------------------------------------
// sram_buffer_row_loader
//
// Packs an 8-bit element stream into ARR_WIDTH-byte rows and writes one row
// per write cycle into the wide SRAM buffer, covering rows 0..rows_tgt-1,
// then pulses done for one cycle.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-high reset
//   bus    sram_buffer_row_loader_if.slave
//            start/num_rows  begin a load (sampled in IDLE only)
//            s_valid/s_data/s_ready  element stream, lane 0 first
//            sram_csb/sram_web/sram_addr/sram_wdata  registered SRAM pins
//            busy (FILL or WRITE), done (one-cycle completion pulse)
// ---------------------------------------------------------------------------
module sram_buffer_row_loader #(
    parameter int ARR_WIDTH = 16,
    parameter int ADDR_W    = 7,
    parameter int DEPTH     = 2**ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    sram_buffer_row_loader_if.slave   bus
);

    localparam int LANE_W = (ARR_WIDTH > 1) ? $clog2(ARR_WIDTH) : 1;
    // Row target must be able to hold DEPTH itself, not just DEPTH-1.
    localparam int TGT_W  = $clog2(DEPTH + 1);
    localparam int ROW_W  = ARR_WIDTH * 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [TGT_W-1:0]    rows_tgt_q, rows_tgt_d;
    logic [ROW_W-1:0]    staging_q, staging_d;
    logic                sram_csb_q, sram_csb_d;
    logic                sram_web_q, sram_web_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [ROW_W-1:0]    sram_wdata_q, sram_wdata_d;

    logic [TGT_W-1:0]    rows_req;
    logic                handshake;
    logic                last_lane;
    logic                last_row;
    logic                s_ready_o;
    logic                busy_o;
    logic                done_o;

    // Requested row count clamped to the buffer depth so the address never
    // wraps past DEPTH-1.
    always_comb begin
        if (int'(bus.num_rows) > DEPTH) begin
            rows_req = TGT_W'(DEPTH);
        end else begin
            rows_req = TGT_W'(bus.num_rows);
        end
    end

    assign handshake = (state_q == S_FILL) && bus.s_valid;
    assign last_lane = (lane_q == LANE_W'(ARR_WIDTH - 1));
    assign last_row  = ((TGT_W'(row_q) + TGT_W'(1)) == rows_tgt_q);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: asynchronous reset appears in the sensitivity list; every
    // sequential assignment is non-blocking so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (rows_req == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (handshake && last_lane) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = last_row ? S_DONE : S_FILL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state-decoded outputs (depend on the state register only)
    // -----------------------------------------------------------------------
    always_comb begin
        s_ready_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        unique case (state_q)
            S_FILL: begin
                s_ready_o = 1'b1;
                busy_o    = 1'b1;
            end
            S_WRITE: begin
                busy_o    = 1'b1;
            end
            S_DONE: begin
                done_o    = 1'b1;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: lane/row counters, staging row, registered SRAM pins
    // -----------------------------------------------------------------------
    always_comb begin
        lane_d       = lane_q;
        row_d        = row_q;
        rows_tgt_d   = rows_tgt_q;
        staging_d    = staging_q;
        sram_csb_d   = 1'b1;
        sram_web_d   = 1'b1;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rows_tgt_d = rows_req;
                    lane_d     = '0;
                    row_d      = '0;
                end
            end
            S_FILL: begin
                if (handshake) begin
                    staging_d[int'(lane_q)*8 +: 8] = bus.s_data;
                    if (last_lane) begin
                        // The SRAM pins are loaded one cycle early, including
                        // the byte accepted this cycle, so they are valid
                        // straight from flops throughout the WRITE cycle.
                        sram_csb_d   = 1'b0;
                        sram_web_d   = 1'b0;
                        sram_addr_d  = row_q;
                        sram_wdata_d = staging_d;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            S_WRITE: begin
                lane_d = '0;
                if (!last_row) begin
                    row_d = row_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: the staging row is ordinary flops, not a RAM macro, so it is
    // reset with everything else; a partial row never survives a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q       <= '0;
            row_q        <= '0;
            rows_tgt_q   <= '0;
            staging_q    <= '0;
            sram_csb_q   <= 1'b1;
            sram_web_q   <= 1'b1;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            lane_q       <= lane_d;
            row_q        <= row_d;
            rows_tgt_q   <= rows_tgt_d;
            staging_q    <= staging_d;
            sram_csb_q   <= sram_csb_d;
            sram_web_q   <= sram_web_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign bus.s_ready    = s_ready_o;
    assign bus.busy       = busy_o;
    assign bus.done       = done_o;
    assign bus.sram_csb   = sram_csb_q;
    assign bus.sram_web   = sram_web_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_buffer_row_loader.sv
// ---------------------------------------------------------------------------
// tb_sram_buffer_row_loader
//
// Bench for sram_buffer_row_loader: a table of load scenarios plus random
// loads, each checked against a row-packing model (bytes k*16..k*16+15 form
// row k at address k), and hand-written reset / restart sequences.
// ---------------------------------------------------------------------------
module tb_sram_buffer_row_loader;

    localparam int ARR_WIDTH = 16;
    localparam int ADDR_W    = 7;
    localparam int DEPTH     = 128;
    localparam int ROW_W     = ARR_WIDTH * 8;

    logic clk;
    logic reset;

    sram_buffer_row_loader_if #(.ARR_WIDTH(ARR_WIDTH), .ADDR_W(ADDR_W)) bus ();

    sram_buffer_row_loader #(
        .ARR_WIDTH(ARR_WIDTH),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [ROW_W-1:0] act,
                         input logic [ROW_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    int                 cyc = 0;
    logic [ADDR_W-1:0]  wr_addr[$];
    logic [ROW_W-1:0]   wr_data[$];
    int                 wr_cyc[$];
    int                 done_cnt;
    int                 busy_cyc;
    bit                 ready_seen;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (!bus.sram_csb) begin
                wr_addr.push_back(bus.sram_addr);
                wr_data.push_back(bus.sram_wdata);
                wr_cyc.push_back(cyc);
                check("write_web_low", ROW_W'(bus.sram_web), ROW_W'(0));
                check("write_sready_low", ROW_W'(bus.s_ready), ROW_W'(0));
            end
            if (bus.done)    done_cnt++;
            if (bus.busy)    busy_cyc++;
            if (bus.s_ready) ready_seen = 1'b1;
        end
    end

    // ---------------- stimulus and reference model ----------------
    logic [7:0] stim[$];
    int         accepted;
    int         done_k;

    // Runs one load. pattern: 0 random bytes, 1 bytes 1,2,3..., 2 bytes 0,1,2...
    // stop_after >= 0 abandons the load once that many bytes were accepted.
    task automatic run_load(input int n, input int duty, input int pattern,
                            input bit restart_mid, input int stop_after);
        int rows;
        int k;
        rows = (n > DEPTH) ? DEPTH : n;
        stim.delete();
        for (int i = 0; i < rows * ARR_WIDTH; i++) begin
            case (pattern)
                1:       stim.push_back(8'(i + 1));
                2:       stim.push_back(8'(i));
                default: stim.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        @(negedge clk);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cnt = 0; busy_cyc = 0; ready_seen = 1'b0;
        accepted = 0; done_k = -1;
        bus.start    = 1'b1;
        bus.num_rows = 8'(n);
        k = 0;
        while (1) begin
            @(negedge clk);
            k++;
            bus.start = (restart_mid && k == 20) ? 1'b1 : 1'b0;
            if (bus.done) begin
                done_k = k;
                bus.s_valid = 1'b0;
                break;
            end
            if (stop_after >= 0 && accepted == stop_after) begin
                bus.s_valid = 1'b0;
                break;
            end
            if (k > 20000) begin
                check("load_timeout", ROW_W'(1), ROW_W'(0));
                break;
            end
            if (accepted < stim.size() && $urandom_range(0, 99) < duty) begin
                bus.s_valid = 1'b1;
                bus.s_data  = stim[accepted];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'($urandom_range(0, 255));
            end
            // s_ready depends only on state, so this predicts the handshake
            // at the coming rising edge.
            if (bus.s_valid && bus.s_ready) accepted++;
        end
        bus.start = 1'b0;
    endtask

    task automatic verify_load(input string tag, input int n, input int duty,
                               input int exp_writes, input int exp_last_addr);
        int rows;
        logic [ROW_W-1:0] exp_row;
        rows = (n > DEPTH) ? DEPTH : n;
        repeat (3) @(negedge clk);
        check({tag, "_nwrites"}, ROW_W'(wr_addr.size()), ROW_W'(exp_writes));
        check({tag, "_accepted"}, ROW_W'(accepted), ROW_W'(rows * ARR_WIDTH));
        check({tag, "_done_cnt"}, ROW_W'(done_cnt), ROW_W'(1));
        for (int r = 0; r < wr_addr.size() && r < rows; r++) begin
            exp_row = '0;
            for (int l = 0; l < ARR_WIDTH; l++) exp_row[l*8 +: 8] = stim[r*ARR_WIDTH + l];
            check({tag, "_addr"}, ROW_W'(wr_addr[r]), ROW_W'(r));
            check({tag, "_wdata"}, wr_data[r], exp_row);
        end
        if (exp_writes > 0 && wr_addr.size() > 0) begin
            check({tag, "_last_addr"}, ROW_W'(wr_addr[wr_addr.size()-1]),
                  ROW_W'(exp_last_addr));
            check({tag, "_addr_hold"}, ROW_W'(bus.sram_addr), ROW_W'(exp_last_addr));
        end
        if (rows == 0) begin
            check({tag, "_no_ready"}, ROW_W'(ready_seen), ROW_W'(0));
        end
        if (duty >= 100) begin
            check({tag, "_done_time"}, ROW_W'(done_k), ROW_W'(rows * (ARR_WIDTH + 1) + 1));
            check({tag, "_busy_cycles"}, ROW_W'(busy_cyc), ROW_W'(rows * (ARR_WIDTH + 1)));
            for (int r = 1; r < wr_cyc.size(); r++) begin
                check({tag, "_spacing"}, ROW_W'(wr_cyc[r] - wr_cyc[r-1]), ROW_W'(ARR_WIDTH + 1));
            end
        end
        check({tag, "_idle_csb"}, ROW_W'(bus.sram_csb), ROW_W'(1));
        check({tag, "_idle_busy"}, ROW_W'(bus.busy), ROW_W'(0));
    endtask

    typedef struct {
        string name;
        int    num_rows;
        int    duty;
        int    pattern;
        bit    restart_mid;
        int    exp_writes;
        int    exp_last_addr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"one_row",     1, 100, 1, 1'b0,   1,   0});
        vecs.push_back('{"three_rows",  3, 100, 2, 1'b0,   3,   2});
        vecs.push_back('{"gappy_row",   1,  50, 0, 1'b0,   1,   0});
        vecs.push_back('{"zero_rows",   0, 100, 0, 1'b0,   0,   0});
        vecs.push_back('{"clamp_200", 200, 100, 0, 1'b0, 128, 127});
        vecs.push_back('{"restart",     2, 100, 0, 1'b1,   2,   1});
        vecs.push_back('{"gappy_five",  5,  70, 0, 1'b1,   5,   4});

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.num_rows = '0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", ROW_W'(bus.s_ready),  ROW_W'(0));
        check("rst_csb",     ROW_W'(bus.sram_csb), ROW_W'(1));
        check("rst_web",     ROW_W'(bus.sram_web), ROW_W'(1));
        check("rst_addr",    ROW_W'(bus.sram_addr), ROW_W'(0));
        check("rst_wdata",   bus.sram_wdata,       ROW_W'(0));
        check("rst_busy",    ROW_W'(bus.busy),     ROW_W'(0));
        check("rst_done",    ROW_W'(bus.done),     ROW_W'(0));
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_load(vecs[i].num_rows, vecs[i].duty, vecs[i].pattern,
                     vecs[i].restart_mid, -1);
            verify_load(vecs[i].name, vecs[i].num_rows, vecs[i].duty,
                        vecs[i].exp_writes, vecs[i].exp_last_addr);
        end

        for (int t = 0; t < 6; t++) begin
            int n;
            int duty;
            n    = $urandom_range(0, 10);
            duty = $urandom_range(30, 100);
            run_load(n, duty, 0, 1'(($urandom_range(0, 1))), -1);
            verify_load("random", n, duty, n, n - 1);
        end

        // Reset after 9 bytes of row 2 (two full rows already written).
        run_load(3, 100, 0, 1'b0, 2 * ARR_WIDTH + 9);
        check("mid_rst_pre_ready", ROW_W'(bus.s_ready), ROW_W'(1));
        #2 reset = 1'b1;
        #1;
        check("mid_rst_s_ready", ROW_W'(bus.s_ready),  ROW_W'(0));
        check("mid_rst_csb",     ROW_W'(bus.sram_csb), ROW_W'(1));
        check("mid_rst_web",     ROW_W'(bus.sram_web), ROW_W'(1));
        check("mid_rst_busy",    ROW_W'(bus.busy),     ROW_W'(0));
        check("mid_rst_addr",    ROW_W'(bus.sram_addr), ROW_W'(0));
        check("mid_rst_nwrites", ROW_W'(wr_addr.size()), ROW_W'(2));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_load(1, 100, 0, 1'b0, -1);
        verify_load("after_rst", 1, 100, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
